// File: rtl/nanofs_pkg.sv
// Shared nanofs definitions: on-disk header constants, header byte offsets and the
// state encoding used by both the format path and the boot-time superblock checker.
package nanofs_pkg;

  localparam logic [15:0] NANOFS_MAGIC     = 16'h4e61;
  localparam logic [7:0]  NANOFS_BSIZE_CODE = 8'h01;

  localparam int OFS_MAGIC0 = 0;
  localparam int OFS_MAGIC1 = 1;
  localparam int OFS_BSIZE  = 2;
  localparam int OFS_RSVD   = 3;
  localparam int OFS_START0 = 4;
  localparam int OFS_START1 = 5;
  localparam int OFS_START2 = 6;
  localparam int OFS_START3 = 7;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_OPEN       = 4'd1,
    ST_WAIT_OPEN  = 4'd2,
    ST_SEND       = 4'd3,
    ST_WAIT_BYTE  = 4'd4,
    ST_CLOSE      = 4'd5,
    ST_WAIT_CLOSE = 4'd6,
    ST_SUCCESS    = 4'd7,
    ST_ERROR      = 4'd8
  } nanofs_state_e;

  // Values captured when a format is requested.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] start_reg;
  } fmt_req_t;

endpackage

// File: rtl/nanofs_sb_byte_gen.sv
// Maps a byte index within the superblock to its content: 8-byte header, then zeros.
module nanofs_sb_byte_gen
  import nanofs_pkg::*;
#(
  parameter int          CW              = 10,
  parameter logic [15:0] MAGIC           = NANOFS_MAGIC,
  parameter logic [7:0]  BLOCK_SIZE_CODE = NANOFS_BSIZE_CODE
) (
  input  logic [CW-1:0] idx_i,
  input  logic [31:0]   start_reg_i,
  output logic [7:0]    byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      CW'(OFS_MAGIC0): byte_o = MAGIC[7:0];
      CW'(OFS_MAGIC1): byte_o = MAGIC[15:8];
      CW'(OFS_BSIZE):  byte_o = BLOCK_SIZE_CODE;
      CW'(OFS_RSVD):   byte_o = 8'h00;
      CW'(OFS_START0): byte_o = start_reg_i[7:0];
      CW'(OFS_START1): byte_o = start_reg_i[15:8];
      CW'(OFS_START2): byte_o = start_reg_i[23:16];
      CW'(OFS_START3): byte_o = start_reg_i[31:24];
      default:         byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/format_nanofs.sv
// Format path: streams one nanofs superblock block to the SD card through the SPI
// block-write core (open block, BLOCK_BYTES byte writes, close, report).
module format_nanofs
  import nanofs_pkg::*;
#(
  parameter int          BLOCK_BYTES     = 512,
  parameter logic [15:0] MAGIC           = NANOFS_MAGIC,
  parameter logic [7:0]  BLOCK_SIZE_CODE = NANOFS_BSIZE_CODE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] begin_address_i,
  input  logic [31:0] start_reg_i,
  output logic        success_o,
  output logic        err_signal_o,
  output logic        spi_w_block_o,
  output logic        spi_w_byte_o,
  output logic [7:0]  spi_data_in_o,
  output logic [31:0] spi_block_addr_o,
  input  logic        spi_busy_i,
  input  logic        spi_err_i,
  output logic [3:0]  debug_leds_o
);

  localparam int CW = $clog2(BLOCK_BYTES) + 1;

  nanofs_state_e state_q, state_d;
  fmt_req_t      req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    gen_byte;
  logic          in_xfer;

  nanofs_sb_byte_gen #(
    .CW              (CW),
    .MAGIC           (MAGIC),
    .BLOCK_SIZE_CODE (BLOCK_SIZE_CODE)
  ) u_byte_gen (
    .idx_i       (cnt_q),
    .start_reg_i (req_q.start_reg),
    .byte_o      (gen_byte)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign in_xfer = state_q inside {ST_OPEN, ST_WAIT_OPEN, ST_SEND, ST_WAIT_BYTE,
                                   ST_CLOSE, ST_WAIT_CLOSE};

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    spi_w_block_o = 1'b0;
    spi_w_byte_o  = 1'b0;
    // Last sent byte is held between pulses so the core sees a stable value.
    spi_data_in_o = data_q;
    success_o     = 1'b0;
    err_signal_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        data_d = '0;
        if (start_i) begin
          req_d.addr      = begin_address_i;
          req_d.start_reg = start_reg_i;
          state_d         = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (!spi_busy_i) begin
          spi_w_block_o = 1'b1;
          state_d       = ST_WAIT_OPEN;
        end
      end
      ST_WAIT_OPEN: begin
        spi_w_block_o = 1'b1;
        if (!spi_busy_i) state_d = ST_SEND;
      end
      ST_SEND: begin
        spi_w_block_o = 1'b1;
        spi_w_byte_o  = 1'b1;
        spi_data_in_o = gen_byte;
        data_d        = gen_byte;
        cnt_d         = cnt_q + 1'b1;
        state_d       = ST_WAIT_BYTE;
      end
      ST_WAIT_BYTE: begin
        spi_w_block_o = 1'b1;
        if (!spi_busy_i) state_d = (cnt_q == CW'(BLOCK_BYTES)) ? ST_CLOSE : ST_SEND;
      end
      ST_CLOSE:      state_d = ST_WAIT_CLOSE;
      ST_WAIT_CLOSE: if (!spi_busy_i) state_d = ST_SUCCESS;
      ST_SUCCESS: begin
        success_o = 1'b1;
        if (!start_i) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        err_signal_o = 1'b1;
        if (!start_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A core error aborts the block immediately; strobes are cut in the same cycle.
    if (in_xfer && spi_err_i) begin
      state_d       = ST_ERROR;
      cnt_d         = cnt_q;
      spi_w_block_o = 1'b0;
      spi_w_byte_o  = 1'b0;
    end
  end

  assign spi_block_addr_o = req_q.addr;
  assign debug_leds_o     = state_q;

endmodule

// File: tb/tb_format_nanofs.sv
// Directed bench for format_nanofs: header/zero-fill content, busy stall, error abort,
// mid-block reset, input latching.
module tb_format_nanofs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        spi_busy = 1'b0;
  logic        spi_err = 1'b0;
  logic [31:0] begin_address = '0;
  logic [31:0] start_reg = '0;
  logic        success, err_signal, spi_w_block, spi_w_byte;
  logic [7:0]  spi_data_in;
  logic [31:0] spi_block_addr;
  logic [3:0]  debug_leds;

  int checks = 0;
  int failures = 0;

  logic [7:0] cap [0:1023];
  int         npulse = 0;
  bit         stray = 1'b0;

  always #5 clk = ~clk;

  format_nanofs dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .begin_address_i  (begin_address),
    .start_reg_i      (start_reg),
    .success_o        (success),
    .err_signal_o     (err_signal),
    .spi_w_block_o    (spi_w_block),
    .spi_w_byte_o     (spi_w_byte),
    .spi_data_in_o    (spi_data_in),
    .spi_block_addr_o (spi_block_addr),
    .spi_busy_i       (spi_busy),
    .spi_err_i        (spi_err),
    .debug_leds_o     (debug_leds)
  );

  // Advance to the next falling edge and record any byte strobe seen there.
  task automatic tick();
    @(negedge clk);
    if (spi_w_byte) begin
      if (npulse < 1024) cap[npulse] = spi_data_in;
      npulse++;
      if (!spi_w_block) stray = 1'b1;
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] sr);
    case (i)
      0:       return 8'h61;
      1:       return 8'h4e;
      2:       return 8'h01;
      4:       return sr[7:0];
      5:       return sr[15:8];
      6:       return sr[23:16];
      7:       return sr[31:24];
      default: return 8'h00;
    endcase
  endfunction

  // Start a format, optionally holding busy for 'hold' cycles and swapping the inputs
  // after the first cycle; returns cycles to success, or -1 if it never came.
  task automatic run_block(input logic [31:0] a, input logic [31:0] sr, input int hold,
                           input logic [31:0] a2, output int cyc);
    npulse = 0; stray = 1'b0; cyc = 0;
    begin_address = a; start_reg = sr; spi_busy = (hold > 0); start = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tick(); cyc++;
      if (spi_w_block) stray = 1'b1;
      if (cyc == 1) begin begin_address = a2; start_reg = ~sr; end
    end
    spi_busy = 1'b0;
    while (!success && cyc < 5000) begin
      tick(); cyc++;
      if (cyc == 1) begin begin_address = a2; start_reg = ~sr; end
    end
    if (!success) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    checks++; if ({success, err_signal, spi_w_block, spi_w_byte} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b want 0000", {success, err_signal, spi_w_block, spi_w_byte}); end
    checks++; if (spi_data_in !== 8'h00) begin
      failures++; $display("FAIL reset_data: got %h want 00", spi_data_in); end
    checks++; if (spi_block_addr !== 32'h0) begin
      failures++; $display("FAIL reset_addr: got %h want 0", spi_block_addr); end
    checks++; if (debug_leds !== 4'd0) begin
      failures++; $display("FAIL reset_state: got %0d want 0", debug_leds); end
    rst_n = 1'b1; tick(); tick();
    checks++; if (debug_leds !== 4'd0 || spi_w_block !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: state %0d wblk %b want 0 0", debug_leds, spi_w_block); end
  endtask

  task automatic test_basic_block();
    int cyc, bad;
    run_block(32'h0, 32'h0000_0800, 0, 32'h0, cyc);
    checks++; if (cyc !== 1029) begin
      failures++; $display("FAIL basic_latency: got %0d want 1029", cyc); end
    checks++; if (npulse !== 512) begin
      failures++; $display("FAIL basic_pulses: got %0d want 512", npulse); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (cap[i] !== exp_byte(i, 32'h0000_0800)) begin
        failures++; $display("FAIL basic_hdr[%0d]: got %h want %h", i, cap[i], exp_byte(i, 32'h0000_0800)); end
    end
    for (int i = 8; i < 512; i++) if (cap[i] !== 8'h00) bad++;
    checks++; if (bad !== 0) begin
      failures++; $display("FAIL basic_zero_fill: %0d nonzero bytes want 0", bad); end
    checks++; if (spi_block_addr !== 32'h0 || debug_leds !== 4'd7 || spi_w_block !== 1'b0) begin
      failures++; $display("FAIL basic_done: addr %h state %0d wblk %b want 0 7 0", spi_block_addr, debug_leds, spi_w_block); end
    checks++; if (stray !== 1'b0) begin
      failures++; $display("FAIL basic_strobe_outside_block: got 1 want 0"); end
    start = 1'b0; tick();
    checks++; if (success !== 1'b0 || debug_leds !== 4'd0) begin
      failures++; $display("FAIL basic_release: success %b state %0d want 0 0", success, debug_leds); end
  endtask

  task automatic test_busy_stall();
    int cyc;
    run_block(32'h0000_0100, 32'h0000_0800, 20, 32'h0000_0100, cyc);
    checks++; if (stray !== 1'b0) begin
      failures++; $display("FAIL stall_wblk_early: got 1 want 0"); end
    checks++; if (cyc !== 1048) begin
      failures++; $display("FAIL stall_latency: got %0d want 1048", cyc); end
    checks++; if (npulse !== 512 || cap[1] !== 8'h4e || cap[5] !== 8'h08) begin
      failures++; $display("FAIL stall_content: pulses %0d b1 %h b5 %h want 512 4e 08", npulse, cap[1], cap[5]); end
    start = 1'b0; tick();
  endtask

  task automatic test_spi_error();
    int cyc = 0;
    npulse = 0; begin_address = 32'h7; start_reg = 32'h1; start = 1'b1;
    while (npulse < 101 && cyc < 3000) begin tick(); cyc++; end
    checks++; if (npulse !== 101 || spi_w_byte !== 1'b1) begin
      failures++; $display("FAIL err_reach_byte100: pulses %0d strobe %b want 101 1", npulse, spi_w_byte); end
    spi_err = 1'b1; #1;
    checks++; if (spi_w_byte !== 1'b0 || spi_w_block !== 1'b0) begin
      failures++; $display("FAIL err_strobe_drop: wbyte %b wblk %b want 0 0", spi_w_byte, spi_w_block); end
    tick();
    checks++; if (err_signal !== 1'b1 || debug_leds !== 4'd8 || spi_w_block !== 1'b0) begin
      failures++; $display("FAIL err_state: err %b state %0d wblk %b want 1 8 0", err_signal, debug_leds, spi_w_block); end
    spi_err = 1'b0;
    repeat (10) tick();
    checks++; if (npulse !== 101 || err_signal !== 1'b1 || success !== 1'b0) begin
      failures++; $display("FAIL err_hold: pulses %0d err %b succ %b want 101 1 0", npulse, err_signal, success); end
    start = 1'b0; tick();
    checks++; if (err_signal !== 1'b0 || debug_leds !== 4'd0) begin
      failures++; $display("FAIL err_release: err %b state %0d want 0 0", err_signal, debug_leds); end
  endtask

  task automatic test_mid_reset();
    int cyc = 0;
    npulse = 0; begin_address = 32'h33; start_reg = 32'h5; start = 1'b1;
    while (npulse < 6 && cyc < 3000) begin tick(); cyc++; end
    rst_n = 1'b0; #1;
    checks++; if ({success, err_signal, spi_w_block, spi_w_byte} !== 4'b0000 || spi_data_in !== 8'h00) begin
      failures++; $display("FAIL rst_mid_outputs: flags %b data %h want 0000 00", {success, err_signal, spi_w_block, spi_w_byte}, spi_data_in); end
    checks++; if (debug_leds !== 4'd0 || spi_block_addr !== 32'h0) begin
      failures++; $display("FAIL rst_mid_state: state %0d addr %h want 0 0", debug_leds, spi_block_addr); end
    repeat (3) tick();
    checks++; if (npulse !== 6 || spi_w_block !== 1'b0) begin
      failures++; $display("FAIL rst_mid_quiet: pulses %0d wblk %b want 6 0", npulse, spi_w_block); end
    start = 1'b0; rst_n = 1'b1; tick();
    run_block(32'h40, 32'h1234_5678, 0, 32'h40, cyc);
    checks++; if (cyc !== 1029 || npulse !== 512) begin
      failures++; $display("FAIL rst_restart_run: cycles %0d pulses %0d want 1029 512", cyc, npulse); end
    checks++; if (cap[0] !== 8'h61 || cap[4] !== 8'h78 || cap[7] !== 8'h12 || spi_block_addr !== 32'h40) begin
      failures++; $display("FAIL rst_restart_data: b0 %h b4 %h b7 %h addr %h want 61 78 12 40", cap[0], cap[4], cap[7], spi_block_addr); end
    start = 1'b0; tick();
  endtask

  task automatic test_input_latch();
    int cyc;
    run_block(32'h10, 32'hcafe_f00d, 0, 32'h20, cyc);
    checks++; if (spi_block_addr !== 32'h10) begin
      failures++; $display("FAIL latch_addr: got %h want 10", spi_block_addr); end
    checks++; if ({cap[7], cap[6], cap[5], cap[4]} !== 32'hcafe_f00d || cyc !== 1029) begin
      failures++; $display("FAIL latch_start_reg: got %h cycles %0d want cafef00d 1029", {cap[7], cap[6], cap[5], cap[4]}, cyc); end
    start = 1'b0; tick();
  endtask

  task automatic test_deadbeef();
    int cyc;
    run_block(32'h99, 32'hdead_beef, 0, 32'h99, cyc);
    checks++; if (cap[4] !== 8'hef || cap[5] !== 8'hbe || cap[6] !== 8'had || cap[7] !== 8'hde) begin
      failures++; $display("FAIL dbeef_bytes: got %h %h %h %h want ef be ad de", cap[4], cap[5], cap[6], cap[7]); end
    checks++; if (cap[0] !== 8'h61 || cap[1] !== 8'h4e || cap[2] !== 8'h01 || cap[3] !== 8'h00) begin
      failures++; $display("FAIL dbeef_magic: got %h %h %h %h want 61 4e 01 00", cap[0], cap[1], cap[2], cap[3]); end
    checks++; if (success !== 1'b1 || npulse !== 512 || cap[511] !== 8'h00) begin
      failures++; $display("FAIL dbeef_done: succ %b pulses %0d last %h want 1 512 00", success, npulse, cap[511]); end
    start = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_basic_block();
    test_busy_stall();
    test_spi_error();
    test_mid_reset();
    test_input_latch();
    test_deadbeef();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
